// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter.
// Two writeback requesters (A = execute, B = load unit) share one RF write
// port through round-robin valid/ready arbitration. The winning write is
// registered onto the RF port. A 32-entry pending-write scoreboard tracks
// registers with an issued but not yet landed producer so decode can stall.
module rf_writeback_arbiter #(
  parameter int data_width = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,       // async, active low
  input  logic                  i_a_valid,
  input  logic [4:0]            i_a_addr,
  input  logic [data_width-1:0] i_a_data,
  output logic                  o_a_ready,
  input  logic                  i_b_valid,
  input  logic [4:0]            i_b_addr,
  input  logic [data_width-1:0] i_b_data,
  output logic                  o_b_ready,
  input  logic                  i_issue_en,
  input  logic [4:0]            i_issue_rd,
  input  logic [4:0]            i_rs1_addr,
  input  logic [4:0]            i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rf_en,
  output logic [4:0]            o_write_addr,
  output logic [data_width-1:0] o_write_data,
  output logic [31:0]           o_busy_vec
);

  // Round-robin state: 1 means B has priority on the next contended cycle.
  // Out of reset A has priority; each grant hands priority to the other side.
  logic                  r_prio_b;
  logic                  r_rf_en;
  logic [4:0]            r_waddr;
  logic [data_width-1:0] r_wdata;
  logic [31:0]           r_busy;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_accept;
  logic [4:0]            w_acc_addr;
  logic [data_width-1:0] w_acc_data;
  logic                  w_acc_real;
  logic [31:0]           w_busy_nxt;

  // Grant: sole requester wins; on contention the prioritised side wins.
  always_comb begin
    w_grant_a  = i_a_valid && (!i_b_valid || !r_prio_b);
    w_grant_b  = i_b_valid && (!i_a_valid ||  r_prio_b);
    w_accept   = w_grant_a || w_grant_b;
    w_acc_addr = w_grant_a ? i_a_addr : i_b_addr;
    w_acc_data = w_grant_a ? i_a_data : i_b_data;
    // x0 writes handshake normally but never reach the RF
    w_acc_real = w_accept && (w_acc_addr != 5'd0);
  end

  // Scoreboard next state: landing write clears, issue sets; set applied
  // last so a newer producer of the same register stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_en)
      w_busy_nxt[r_waddr] = 1'b0;
    if (i_issue_en && (i_issue_rd != 5'd0))
      w_busy_nxt[i_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Arbitration pointer, registered RF write port and scoreboard state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prio_b <= 1'b0;
      r_rf_en  <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= '0;
    end else begin
      if (w_grant_a)
        r_prio_b <= 1'b1;
      else if (w_grant_b)
        r_prio_b <= 1'b0;
      r_rf_en <= w_acc_real;
      if (w_acc_real) begin
        r_waddr <= w_acc_addr;
        r_wdata <= w_acc_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign o_a_ready    = w_grant_a;
  assign o_b_ready    = w_grant_b;
  assign o_rf_en      = r_rf_en;
  assign o_write_addr = r_waddr;
  assign o_write_data = r_wdata;
  assign o_busy_vec   = r_busy;
  // No bypass: a write landing this cycle still reads as busy.
  assign o_rs1_busy   = r_busy[i_rs1_addr];
  assign o_rs2_busy   = r_busy[i_rs2_addr];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed stimulus pushes expected RF
// writes into a queue; a negedge monitor pops and compares each write the
// DUT puts on the RF port. Handshake and scoreboard values are checked inline.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, issue_en;
  logic [4:0]  a_addr, b_addr, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rs1_busy, rs2_busy, rf_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy_vec;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.data_width(32)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_issue_en(issue_en), .i_issue_rd(issue_rd),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_rf_en(rf_en), .o_write_addr(write_addr), .o_write_data(write_data),
    .o_busy_vec(busy_vec)
  );

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                 write_addr, write_data);
      end else begin
        chk("rf_write", {write_addr, write_data}, exp_q.pop_front());
      end
    end
  end

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // One cycle: drive at negedge, check readies, return 1ns after posedge.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ie, input logic [4:0] ird,
                      input logic ear, input logic ebr, input string tag);
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    issue_en = ie; issue_rd = ird;
    #1;
    chk({tag, "_a_ready"}, {36'd0, a_ready}, {36'd0, ear});
    chk({tag, "_b_ready"}, {36'd0, b_ready}, {36'd0, ebr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    a_valid = 0; b_valid = 0; issue_en = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_en = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    #12;
    chk("reset_rf_en", {36'd0, rf_en}, 37'd0);
    chk("reset_waddr", {32'd0, write_addr}, 37'd0);
    chk("reset_wdata", {5'd0, write_data}, 37'd0);
    chk("reset_busy",  {5'd0, busy_vec}, 37'd0);
    @(negedge clk); rst_n = 1;

    // 1: reset mid-write drops the registered write and the scoreboard
    step(1, 6, 32'h1234_5678, 0, 0, 0, 1, 12, 1, 0, "t1");
    chk("t1_busy_set", {5'd0, busy_vec}, 37'h0000_1000);
    rst_n = 0;
    a_valid = 0; issue_en = 0;
    #1;
    chk("t1_rst_rf_en", {36'd0, rf_en}, 37'd0);
    chk("t1_rst_busy",  {5'd0, busy_vec}, 37'd0);
    @(negedge clk); rst_n = 1;
    idle("t1_idle0");
    idle("t1_idle1");
    chk("t1_no_write", {36'd0, rf_en}, 37'd0);

    // 2: single A write
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0, "t2");
    expect_wr(5, 32'hDEAD_BEEF);
    chk("t2_rf_en", {36'd0, rf_en}, 37'd1);
    idle("t2_idle");
    chk("t2_rf_en_drop", {36'd0, rf_en}, 37'd0);
    chk("t2_addr_hold", {32'd0, write_addr}, 37'd5);

    // 3: contention from reset: A, then B, then A again
    pulse_reset();
    step(1, 3, 32'hAAAA_0003, 1, 4, 32'hBBBB_0004, 0, 0, 1, 0, "t3c1");
    expect_wr(3, 32'hAAAA_0003);
    step(1, 3, 32'hAAAA_0033, 1, 4, 32'hBBBB_0004, 0, 0, 0, 1, "t3c2");
    expect_wr(4, 32'hBBBB_0004);
    chk("t3_b2b_rf_en", {36'd0, rf_en}, 37'd1);
    step(1, 3, 32'hAAAA_0033, 0, 0, 0, 0, 0, 1, 0, "t3c3");
    expect_wr(3, 32'hAAAA_0033);
    idle("t3_idle");

    // 4: scoreboard set and clear
    rs1_addr = 7; rs2_addr = 8;
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, "t4_issue");
    chk("t4_busy_vec", {5'd0, busy_vec}, 37'h0000_0080);
    chk("t4_rs1_busy", {36'd0, rs1_busy}, 37'd1);
    chk("t4_rs2_busy", {36'd0, rs2_busy}, 37'd0);
    step(1, 7, 32'h0000_0077, 0, 0, 0, 0, 0, 1, 0, "t4_wr");
    expect_wr(7, 32'h0000_0077);
    chk("t4_busy_landing", {36'd0, rs1_busy}, 37'd1);
    idle("t4_idle");
    chk("t4_busy_clear", {5'd0, busy_vec}, 37'd0);

    // 5: set/clear collision on x9, set wins
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, "t5_issue");
    step(1, 9, 32'h0000_0099, 0, 0, 0, 0, 0, 1, 0, "t5_wr");
    expect_wr(9, 32'h0000_0099);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, "t5_coll");
    chk("t5_busy_set_wins", {5'd0, busy_vec}, 37'h0000_0200);
    idle("t5_idle");
    chk("t5_busy_hold", {5'd0, busy_vec}, 37'h0000_0200);

    // 6: x0 write handshakes but never writes; issue rd=0 ignored
    step(1, 0, 32'h0000_0005, 0, 0, 0, 1, 0, 1, 0, "t6");
    chk("t6_rf_en", {36'd0, rf_en}, 37'd0);
    chk("t6_busy", {5'd0, busy_vec}, 37'h0000_0200);
    idle("t6_idle");

    idle("drain");
    chk("queue_drained", 37'(exp_q.size()), 37'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
